// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - shares one sdram_master request port among video, blitter and CPU clients
module sdram_arbiter #(
  parameter int BURST_LEN = 640
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        vid_req,
  input  logic [24:0] vid_addr,
  output logic        vid_grant,
  output logic        vid_valid,
  output logic        vid_done,
  input  logic        blt_req,
  input  logic        blt_burst,
  input  logic [24:0] blt_addr,
  input  logic [31:0] blt_wdata,
  output logic        blt_grant,
  output logic        blt_valid,
  output logic        blt_done,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [24:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_done,
  output logic [31:0] rd_data,
  output logic        m_read_req,
  output logic        m_write_req,
  output logic        m_burst_req,
  output logic        m_blitter_read,
  output logic [24:0] m_address,
  output logic [31:0] m_write_data,
  input  logic        m_ready,
  input  logic        m_burst_finished,
  input  logic [31:0] m_data,
  output logic        burst_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_SINGLE, WAIT_BURST} state_t;
  typedef enum logic [1:0] {OWN_V, OWN_B, OWN_C} owner_t;
  typedef enum logic [1:0] {OP_BURST, OP_READ, OP_WRITE} op_t;

  localparam logic [10:0] BURST_LEN_W = 11'(BURST_LEN);
  localparam logic [10:0] WCNT_MAX    = 11'h7FF;

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  op_t         op_q, op_d;
  logic [24:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic [10:0] wcnt_q, wcnt_d;
  logic        err_q, err_d;
  // rr_c_q = 1 means C was served last among B/C, so B wins the next contest
  logic        rr_c_q, rr_c_d;

  logic        cpu_req;
  logic        b_wins;
  logic        c_wins;
  logic        busy;
  logic        complete;
  logic [10:0] wcnt_inc;
  logic [10:0] wcnt_final;

  assign cpu_req = cpu_read | cpu_write;
  assign b_wins  = blt_req & (~cpu_req | rr_c_q);
  assign c_wins  = cpu_req & (~blt_req | ~rr_c_q);
  assign busy    = (state_q != IDLE);

  assign m_address      = addr_q;
  assign m_write_data   = wdata_q;
  assign m_blitter_read = (owner_q == OWN_B);
  assign rd_data        = m_data;
  assign cpu_rdata      = cpu_rdata_q;
  assign burst_err      = err_q;

  assign vid_grant = busy & (owner_q == OWN_V);
  assign blt_grant = busy & (owner_q == OWN_B);

  assign wcnt_inc   = (wcnt_q == WCNT_MAX) ? wcnt_q : wcnt_q + 11'd1;
  assign wcnt_final = m_ready ? wcnt_inc : wcnt_q;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    wcnt_d      = wcnt_q;
    err_d       = err_q;
    rr_c_d      = rr_c_q;
    complete    = 1'b0;
    m_burst_req = 1'b0;
    m_read_req  = 1'b0;
    m_write_req = 1'b0;
    vid_valid   = 1'b0;
    blt_valid   = 1'b0;
    vid_done    = 1'b0;
    blt_done    = 1'b0;
    cpu_done    = 1'b0;

    case (state_q)
      IDLE: begin
        if (vid_req) begin
          owner_d = OWN_V;
          op_d    = OP_BURST;
          addr_d  = vid_addr;
          wcnt_d  = 11'd0;
          state_d = ISSUE;
        end else if (b_wins) begin
          owner_d = OWN_B;
          op_d    = blt_burst ? OP_BURST : OP_WRITE;
          addr_d  = blt_addr;
          wdata_d = blt_wdata;
          wcnt_d  = 11'd0;
          state_d = ISSUE;
        end else if (c_wins) begin
          // a simultaneous write stays pending until a later grant
          owner_d = OWN_C;
          op_d    = cpu_read ? OP_READ : OP_WRITE;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          wcnt_d  = 11'd0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        m_burst_req = (op_q == OP_BURST);
        m_read_req  = (op_q == OP_READ);
        m_write_req = (op_q == OP_WRITE);
        state_d     = (op_q == OP_BURST) ? WAIT_BURST : WAIT_SINGLE;
      end
      WAIT_SINGLE: begin
        if (m_ready) begin
          complete = 1'b1;
          if (owner_q == OWN_C && op_q == OP_READ) cpu_rdata_d = m_data;
        end
      end
      WAIT_BURST: begin
        if (m_ready) begin
          wcnt_d    = wcnt_inc;
          vid_valid = (owner_q == OWN_V);
          blt_valid = (owner_q == OWN_B);
        end
        if (m_burst_finished) begin
          complete = 1'b1;
          if (wcnt_final != BURST_LEN_W) err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (complete) begin
      state_d  = IDLE;
      vid_done = (owner_q == OWN_V);
      blt_done = (owner_q == OWN_B);
      cpu_done = (owner_q == OWN_C);
      if (owner_q == OWN_B) rr_c_d = 1'b0;
      if (owner_q == OWN_C) rr_c_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_V;
      op_q        <= OP_BURST;
      addr_q      <= 25'd0;
      wdata_q     <= 32'd0;
      cpu_rdata_q <= 32'd0;
      wcnt_q      <= 11'd0;
      err_q       <= 1'b0;
      rr_c_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      wcnt_q      <= wcnt_d;
      err_q       <= err_d;
      rr_c_q      <= rr_c_d;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - directed bench for sdram_arbiter with a transaction-level reference model
module tb_sdram_arbiter;

  localparam int V = 0, B = 1, C = 2;
  localparam int K_BURST = 0, K_READ = 1, K_WRITE = 2;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        vid_req = 0, blt_req = 0, blt_burst = 0, cpu_read = 0, cpu_write = 0;
  logic [24:0] vid_addr = 0, blt_addr = 0, cpu_addr = 0;
  logic [31:0] blt_wdata = 0, cpu_wdata = 0, m_data = 0;
  logic        m_ready = 0, m_burst_finished = 0;
  logic        vid_grant, vid_valid, vid_done, blt_grant, blt_valid, blt_done, cpu_done;
  logic [31:0] cpu_rdata, rd_data, m_write_data;
  logic        m_read_req, m_write_req, m_burst_req, m_blitter_read, burst_err;
  logic [24:0] m_address;

  int checks = 0;
  int errors = 0;

  sdram_arbiter #(.BURST_LEN(640)) dut (
    .Clk(Clk), .Reset(Reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_grant(vid_grant), .vid_valid(vid_valid), .vid_done(vid_done),
    .blt_req(blt_req), .blt_burst(blt_burst), .blt_addr(blt_addr), .blt_wdata(blt_wdata),
    .blt_grant(blt_grant), .blt_valid(blt_valid), .blt_done(blt_done),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .rd_data(rd_data),
    .m_read_req(m_read_req), .m_write_req(m_write_req), .m_burst_req(m_burst_req),
    .m_blitter_read(m_blitter_read), .m_address(m_address), .m_write_data(m_write_data),
    .m_ready(m_ready), .m_burst_finished(m_burst_finished), .m_data(m_data), .burst_err(burst_err)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction described by who/what/where
  int          md_phase;   // 0 none, 1 request cycle, 2 awaiting completion
  int          md_owner;
  int          md_kind;
  logic [24:0] md_addr;
  logic [31:0] md_wdata;
  int          md_last_bc;
  int          md_words;
  bit          md_err;
  logic [31:0] md_crd;
  bit          md_fin;
  int          md_win;

  always @(negedge Clk) begin
    if (Reset) begin
      md_phase = 0; md_owner = V; md_kind = K_BURST; md_addr = 0; md_wdata = 0;
      md_last_bc = C; md_words = 0; md_err = 0; md_crd = 0;
      chk("rst_grants", {30'd0, vid_grant, blt_grant}, 0);
      chk("rst_strobes", {29'd0, m_burst_req, m_read_req, m_write_req}, 0);
      chk("rst_m_address", 32'(m_address), 0);
      chk("rst_m_write_data", m_write_data, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_burst_err", 32'(burst_err), 0);
    end else begin
      chk("m_burst_req", 32'(m_burst_req), 32'(md_phase == 1 && md_kind == K_BURST));
      chk("m_read_req", 32'(m_read_req), 32'(md_phase == 1 && md_kind == K_READ));
      chk("m_write_req", 32'(m_write_req), 32'(md_phase == 1 && md_kind == K_WRITE));
      chk("vid_grant", 32'(vid_grant), 32'(md_phase != 0 && md_owner == V));
      chk("blt_grant", 32'(blt_grant), 32'(md_phase != 0 && md_owner == B));
      chk("m_blitter_read", 32'(m_blitter_read), 32'(md_owner == B));
      if (md_phase != 0) chk("m_address", 32'(m_address), 32'(md_addr));
      if (md_phase != 0 && md_kind == K_WRITE) chk("m_write_data", m_write_data, md_wdata);
      md_fin = (md_phase == 2) && (md_kind == K_BURST ? m_burst_finished : m_ready);
      chk("vid_valid", 32'(vid_valid), 32'(md_phase == 2 && md_kind == K_BURST && md_owner == V && m_ready));
      chk("blt_valid", 32'(blt_valid), 32'(md_phase == 2 && md_kind == K_BURST && md_owner == B && m_ready));
      chk("vid_done", 32'(vid_done), 32'(md_fin && md_owner == V));
      chk("blt_done", 32'(blt_done), 32'(md_fin && md_owner == B));
      chk("cpu_done", 32'(cpu_done), 32'(md_fin && md_owner == C));
      chk("rd_data", rd_data, m_data);
      chk("cpu_rdata", cpu_rdata, md_crd);
      chk("burst_err", 32'(burst_err), 32'(md_err));

      if (md_phase == 0) begin
        md_win = -1;
        if (vid_req) md_win = V;
        else if (blt_req && (cpu_read || cpu_write)) md_win = (md_last_bc == C) ? B : C;
        else if (blt_req) md_win = B;
        else if (cpu_read || cpu_write) md_win = C;
        if (md_win >= 0) begin
          md_owner = md_win; md_phase = 1; md_words = 0;
          if (md_win == V) begin md_kind = K_BURST; md_addr = vid_addr; end
          else if (md_win == B) begin md_kind = blt_burst ? K_BURST : K_WRITE; md_addr = blt_addr; md_wdata = blt_wdata; end
          else begin md_kind = cpu_read ? K_READ : K_WRITE; md_addr = cpu_addr; md_wdata = cpu_wdata; end
        end
      end else if (md_phase == 1) begin
        md_phase = 2;
      end else begin
        if (md_kind == K_BURST && m_ready && md_words < 2047) md_words++;
        if (md_fin) begin
          if (md_kind == K_BURST && md_words != 640) md_err = 1;
          if (md_owner == C && md_kind == K_READ) md_crd = m_data;
          if (md_owner != V) md_last_bc = md_owner;
          md_phase = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_issue(output int own);
    own = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (m_burst_req || m_read_req || m_write_req) begin
        own = vid_grant ? V : (blt_grant ? B : C);
        break;
      end
    end
    if (own < 0) chk("issue_timeout", 0, 1);
  endtask

  task automatic serve_burst(input int n, input bit fin_last, output int vcnt, output bit done_seen);
    vcnt = 0;
    done_seen = 0;
    tick();
    for (int i = 0; i < n; i++) begin
      m_ready = 1;
      m_data = 32'h5A00_0000 + 32'(i);
      m_burst_finished = fin_last && (i == n - 1);
      #1;
      if (vid_valid || blt_valid) vcnt++;
      if (vid_done || blt_done) done_seen = 1;
      tick();
    end
    if (!fin_last) begin
      m_ready = 0;
      m_burst_finished = 1;
      #1;
      if (vid_done || blt_done) done_seen = 1;
      tick();
    end
    m_ready = 0;
    m_burst_finished = 0;
  endtask

  task automatic serve_single(input logic [31:0] d, output bit done_seen);
    tick();
    m_ready = 1;
    m_data = d;
    #1;
    done_seen = cpu_done || blt_done;
    tick();
    m_ready = 0;
  endtask

  int exp_order[4] = '{B, C, B, C};
  int own;
  int vcnt;
  bit dseen;

  initial begin
    // 1: reset mid-burst
    repeat (2) tick();
    Reset = 0;
    vid_req = 1; vid_addr = 25'd1280;
    tick();
    tick();
    for (int i = 0; i < 100; i++) begin m_ready = 1; tick(); end
    Reset = 1;
    #1;
    chk("t1_vid_grant", 32'(vid_grant), 0);
    chk("t1_m_burst_req", 32'(m_burst_req), 0);
    chk("t1_m_address", 32'(m_address), 0);
    chk("t1_burst_err", 32'(burst_err), 0);
    m_ready = 0; vid_req = 0;
    tick();
    Reset = 0;
    repeat (2) tick();
    chk("t1_idle_after", {30'd0, vid_grant, m_burst_req}, 0);

    // 2: C write alone
    cpu_write = 1; cpu_addr = 25'h0000123; cpu_wdata = 32'hDEADBEEF;
    tick();
    chk("t2_wreq_issue", 32'(m_write_req), 1);
    chk("t2_addr_issue", 32'(m_address), 32'h123);
    tick();
    chk("t2_wreq_once", 32'(m_write_req), 0);
    chk("t2_wdata_hold", m_write_data, 32'hDEADBEEF);
    m_ready = 1;
    #1;
    chk("t2_cpu_done", 32'(cpu_done), 1);
    tick();
    m_ready = 0; cpu_write = 0;
    for (int i = 0; i < 3; i++) begin tick(); chk("t2_no_reissue", 32'(m_write_req), 0); end

    // 3: C read and write together, read first
    cpu_read = 1; cpu_write = 1; cpu_addr = 25'h0000456; cpu_wdata = 32'h01234567;
    tick();
    chk("t3_read_first", {30'd0, m_read_req, m_write_req}, 32'h2);
    serve_single(32'hCAFEF00D, dseen);
    chk("t3_cpu_done", 32'(dseen), 1);
    cpu_read = 0;
    chk("t3_cpu_rdata", cpu_rdata, 32'hCAFEF00D);
    tick();
    chk("t3_write_later", 32'(m_write_req), 1);
    serve_single(32'h0, dseen);
    cpu_write = 0;
    tick();

    // 4: V and C contend, V wins with a full burst
    vid_req = 1; vid_addr = 25'd1280; cpu_read = 1; cpu_addr = 25'h0000789;
    tick();
    chk("t4_v_issue", {29'd0, vid_grant, m_burst_req, m_blitter_read}, 32'h6);
    chk("t4_addr", 32'(m_address), 32'd1280);
    serve_burst(640, 1, vcnt, dseen);
    vid_req = 0;
    chk("t4_valid_cnt", 32'(vcnt), 640);
    chk("t4_vid_done", 32'(dseen), 1);
    chk("t4_burst_err", 32'(burst_err), 0);
    chk("t4_addr_held", 32'(m_address), 32'd1280);
    tick();
    chk("t4_c_after", 32'(m_read_req), 1);
    serve_single(32'h11112222, dseen);
    cpu_read = 0;
    tick();

    // 5: B bursts and C reads alternate
    Reset = 1;
    tick();
    Reset = 0;
    blt_req = 1; blt_burst = 1; blt_addr = 25'h0100000; cpu_read = 1; cpu_addr = 25'h0000042;
    for (int k = 0; k < 4; k++) begin
      wait_issue(own);
      chk($sformatf("t5_order%0d", k), 32'(own), 32'(exp_order[k]));
      if (own == B) begin
        chk("t5_blitter_read", 32'(m_blitter_read), 1);
        serve_burst(640, 1, vcnt, dseen);
      end else if (own == C) begin
        serve_single(32'h33334444 + 32'(k), dseen);
      end
    end
    blt_req = 0; cpu_read = 0;
    tick();

    // 6: short burst sets sticky error
    vid_req = 1; vid_addr = 25'd2560;
    tick();
    serve_burst(639, 0, vcnt, dseen);
    vid_req = 0;
    chk("t6_valid_cnt", 32'(vcnt), 639);
    chk("t6_vid_done", 32'(dseen), 1);
    chk("t6_burst_err", 32'(burst_err), 1);
    cpu_write = 1; cpu_addr = 25'h0000777; cpu_wdata = 32'h55AA55AA;
    tick();
    serve_single(32'h0, dseen);
    cpu_write = 0;
    tick();
    chk("t6_err_sticky", 32'(burst_err), 1);
    Reset = 1;
    #1;
    chk("t6_err_cleared", 32'(burst_err), 0);
    tick();
    Reset = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single sdram_master port among three requesters: video line fetcher (client V), blitter (client B) and CPU/bus bridge (client C).
- Selects one transaction at a time and latches its operation, address and write data.
- Issues a one-cycle request to the master, holds address/data stable until completion, and routes data, valid and done strobes back to the owning client.
- Sits between the clients and the sdram_master request interface.

Parameters:
- BURST_LEN, 640, words expected per burst read; checked at burst completion.

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- vid_req  in  1  V requests a burst read; held until vid_done
- vid_addr  in  25  V burst start word address
- vid_grant  out  1  V owns the master
- vid_valid  out  1  V data word strobe
- vid_done  out  1  V transaction-complete pulse
- blt_req  in  1  B request; held until blt_done
- blt_burst  in  1  1 = burst read, 0 = single write
- blt_addr  in  25  B address
- blt_wdata  in  32  B write data
- blt_grant  out  1  B owns the master
- blt_valid  out  1  B data word strobe
- blt_done  out  1  B complete pulse
- cpu_read  in  1  C single read request; held until cpu_done
- cpu_write  in  1  C single write request; held until cpu_done
- cpu_addr  in  25  C address
- cpu_wdata  in  32  C write data
- cpu_rdata  out  32  C registered read data
- cpu_done  out  1  C complete pulse
- rd_data  out  32  shared read data to V/B; equals m_data, qualify with vid_valid/blt_valid
- m_read_req, m_write_req, m_burst_req  out  1 each  request strobes to master
- m_blitter_read  out  1  1 = unwrapped blitter burst, 0 = frame-wrapped burst
- m_address  out  25  master address
- m_write_data  out  32  master write data
- m_ready  in  1  master ready / data valid strobe
- m_burst_finished  in  1  master burst-complete strobe
- m_data  in  32  master read data
- burst_err  out  1  sticky: a burst ended with word count != BURST_LEN

Behaviour:
- Reset (async):
  - State IDLE.
  - All outputs 0: m_address, m_write_data, cpu_rdata, word counter, burst_err.
  - Round-robin pointer rr points to C, so B wins the first B/C contest.
- States: IDLE, ISSUE, WAIT_SINGLE, WAIT_BURST.
- IDLE, selection priority:
  - V first (strict priority).
  - Otherwise, between B and C, the one not equal to rr. If only one of B/C is requesting, it wins.
  - On a win: latch owner, operation, address and write data into registers; clear the word counter; go to ISSUE.
  - With no request, stay in IDLE; m_address and m_write_data keep their last values.
- C operation select: cpu_read has precedence when cpu_read and cpu_write are both high; the write stays pending for a later grant.
- ISSUE lasts exactly one cycle:
  - Assert exactly one of m_burst_req (V, or B with blt_burst=1), m_read_req (C read) or m_write_req (B with blt_burst=0, or C write).
  - m_blitter_read = 1 only when the owner is B.
  - Next state: WAIT_BURST for bursts, otherwise WAIT_SINGLE.
  - Request strobes are never asserted outside ISSUE. This prevents the master from re-issuing on its return to WAIT.
- Hold rules:
  - m_address, m_write_data and m_blitter_read stay constant from ISSUE until the state returns to IDLE. The master uses the address combinationally and for its burst-length compare.
  - The grant output of the owner is high from ISSUE through the completion cycle.
- WAIT_SINGLE, on m_ready:
  - For a C read, register m_data into cpu_rdata.
  - Pulse the owner's done (combinational, same cycle as m_ready); go to IDLE.
  - Flip rr to the owner if the owner is B or C.
- WAIT_BURST:
  - Each m_ready: owner valid = 1 in the same cycle; rd_data = m_data; word counter +1 (11-bit, saturates at 2047).
  - On m_burst_finished, the counted words include any m_ready in that same cycle. If that total != BURST_LEN, set burst_err.
  - Also on m_burst_finished: pulse owner done, go to IDLE, update rr as above.
- Request behaviour:
  - A request dropped mid-transaction does not abort it; the transaction completes and done still pulses.
  - A new request is evaluated no earlier than the cycle after done, so back-to-back ISSUEs are at least 3 cycles apart.
- Non-owner valid and done outputs stay 0 at all times.
- Reset mid-transaction returns to IDLE immediately; the master must be reset with the same signal.

Test Plan:
1. Assert Reset mid-burst (V granted, word 100) -> immediately vid_grant=0, m_burst_req=0, m_address=0, burst_err=0; after release, state IDLE.
2. C alone: cpu_write=1, cpu_addr=25'h0000123, cpu_wdata=32'hDEADBEEF -> m_write_req high for exactly one cycle, 1 cycle after the request. m_address=25'h0000123 and m_write_data=32'hDEADBEEF are held. cpu_done pulses in the m_ready cycle; m_write_req is not reasserted afterwards.
3. C read with m_data=32'hCAFEF00D at m_ready -> cpu_rdata=32'hCAFEF00D the next cycle, cpu_done in the m_ready cycle. With cpu_read and cpu_write both high, the read is served first.
4. vid_req and cpu_read raised in the same cycle, vid_addr=25'd1280 -> V granted with m_burst_req, m_blitter_read=0 and m_address=1280 held. 640 m_ready pulses give 640 vid_valid; vid_done with m_burst_finished; burst_err=0. The C read is issued afterwards.
5. blt_req (blt_burst=1) and cpu_read held continuously after reset -> grants alternate B, C, B, C; m_blitter_read=1 on every B burst.
6. V burst where m_burst_finished arrives after only 639 m_ready pulses -> burst_err=1 and stays 1 through later clean transactions until Reset.
